// File: rtl/data_table_rd_arbiter.sv
// data_table_rd_arbiter
// Shares the data-table RAM read port (port A) among ENG_CNT lookup engines.
// It grants one engine per cycle in round-robin order. An engine can lock the
// port so that it walks a bucket chain without other engines interleaving.
// Each grant is delayed by RAM_LATENCY cycles, which tells the engine when the
// broadcast read data belongs to it.
// Optional build macro DATA_TABLE_RD_ARB_STARVE_GUARD_EN adds per-engine wait
// counters. When an engine has waited 255 cycles, they break a lock and raise
// the starve_o output.

module data_table_rd_arbiter #(
   parameter int ENG_CNT     = 4,
   parameter int A_WIDTH     = 10,
   parameter int D_WIDTH     = 64,
   parameter int RAM_LATENCY = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [ENG_CNT-1:0]         rd_req_i,
   input  logic [ENG_CNT-1:0]         rd_lock_i,
   input  logic [ENG_CNT*A_WIDTH-1:0] rd_addr_i,
   output logic [ENG_CNT-1:0]         rd_gnt_o,
   output logic [D_WIDTH-1:0]         rd_data_o,
   output logic [ENG_CNT-1:0]         rd_data_val_o,
   output logic [A_WIDTH-1:0]         ram_rd_addr_o,
   output logic                       ram_rd_en_o,
   input  logic [D_WIDTH-1:0]         ram_rd_data_i
`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
   ,
   output logic [ENG_CNT-1:0]         starve_o
`endif
);

   localparam int IDX_W = (ENG_CNT > 1) ? $clog2(ENG_CNT) : 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [A_WIDTH-1:0] addr_hold_q;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [ENG_CNT-1:0] val_pipe_q [RAM_LATENCY];

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (int'(idx) == ENG_CNT - 1) return '0;
      return idx + IDX_W'(1);
   endfunction

`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
   logic [7:0]         wait_cnt_q [ENG_CNT];
   logic [ENG_CNT-1:0] starve_vec;
   logic               starve_hit;
   logic [IDX_W-1:0]   starve_idx;

   // Find engines that waited 255 cycles behind a lock; the lowest index is chosen to be served first
   always_comb begin
      starve_vec = '0;
      starve_idx = '0;
      for (int k = ENG_CNT - 1; k >= 0; k--) begin
         starve_vec[k] = (state_q == ST_LOCKED) && rd_req_i[k] && (wait_cnt_q[k] == 8'hFF);
         if (starve_vec[k]) starve_idx = IDX_W'(k);
      end
      starve_hit = |starve_vec;
   end

   assign starve_o = starve_hit ? (ENG_CNT'(1) << starve_idx) : '0;

   // Count consecutive waiting cycles per engine; a grant or a dropped request clears the count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < ENG_CNT; k++) wait_cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < ENG_CNT; k++) begin
            if (!rd_req_i[k] || rd_gnt_o[k]) wait_cnt_q[k] <= '0;
            else if (wait_cnt_q[k] != 8'hFF) wait_cnt_q[k] <= wait_cnt_q[k] + 8'd1;
         end
      end
   end
`endif

   // Pick the winner: the lock owner only, or else the first requester at or after the pointer
   always_comb begin
      int j;
      j         = 0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (state_q == ST_LOCKED) begin
         if (rd_req_i[owner_q]) begin
            gnt_valid = 1'b1;
            gnt_idx   = owner_q;
         end
      end else begin
         for (int i = ENG_CNT - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= ENG_CNT) j = j - ENG_CNT;
            if (rd_req_i[j]) begin
               gnt_valid = 1'b1;
               gnt_idx   = IDX_W'(j);
            end
         end
      end
   end

   assign rd_gnt_o      = gnt_valid ? (ENG_CNT'(1) << gnt_idx) : '0;
   assign ram_rd_en_o   = gnt_valid;
   assign ram_rd_addr_o = gnt_valid ? rd_addr_i[gnt_idx*A_WIDTH +: A_WIDTH] : addr_hold_q;
   assign rd_data_o     = ram_rd_data_i;
   assign rd_data_val_o = val_pipe_q[RAM_LATENCY-1];

   // Lock and round-robin bookkeeping; the pointer stays frozen while an owner holds the port
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      if (state_q == ST_IDLE) begin
         if (gnt_valid) begin
            ptr_d = next_idx(gnt_idx);
            if (rd_lock_i[gnt_idx]) begin
               state_d = ST_LOCKED;
               owner_d = gnt_idx;
            end
         end
      end else begin
         if (!rd_lock_i[owner_q]) begin
            state_d = ST_IDLE;
            ptr_d   = next_idx(owner_q);
         end
`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
         if (starve_hit) begin
            state_d = ST_IDLE;
            ptr_d   = starve_idx;
         end
`endif
      end
   end

   // Arbiter state registers, plus the last issued address so that an idle cycle leaves the RAM address unchanged
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         addr_hold_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         if (gnt_valid) addr_hold_q <= rd_addr_i[gnt_idx*A_WIDTH +: A_WIDTH];
      end
   end

   // Delay each grant by the RAM latency so the valid strobe lines up with the returning data
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < RAM_LATENCY; i++) val_pipe_q[i] <= '0;
      end else begin
         val_pipe_q[0] <= rd_gnt_o;
         for (int i = 1; i < RAM_LATENCY; i++) val_pipe_q[i] <= val_pipe_q[i-1];
      end
   end

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Testbench for data_table_rd_arbiter.
// It runs two instances on the same stimulus: one with RAM_LATENCY=2 and one with RAM_LATENCY=1.
// Each instance has its own RAM model. The model returns DBASE | address.

module tb_data_table_rd_arbiter;

   localparam logic [63:0] DBASE = 64'hDA7A_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [39:0] addr;

   logic [3:0]  gnt2, val2, gnt1, val1;
   logic [63:0] data2, data1, ram_q2, ram_q1;
   logic [9:0]  ram_addr2, ram_addr1;
   logic        en2, en1;
`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
   logic [3:0]  starve2, starve1;
`endif

   int n_checks = 0;
   int n_bad    = 0;

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   data_table_rd_arbiter #(.ENG_CNT(4), .A_WIDTH(10), .D_WIDTH(64), .RAM_LATENCY(2)) dut (
      .clk_i(clk), .rst_i(rst), .rd_req_i(req), .rd_lock_i(lock), .rd_addr_i(addr),
      .rd_gnt_o(gnt2), .rd_data_o(data2), .rd_data_val_o(val2),
      .ram_rd_addr_o(ram_addr2), .ram_rd_en_o(en2), .ram_rd_data_i(ram_q2)
`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
      , .starve_o(starve2)
`endif
   );

   data_table_rd_arbiter #(.ENG_CNT(4), .A_WIDTH(10), .D_WIDTH(64), .RAM_LATENCY(1)) dut_lat1 (
      .clk_i(clk), .rst_i(rst), .rd_req_i(req), .rd_lock_i(lock), .rd_addr_i(addr),
      .rd_gnt_o(gnt1), .rd_data_o(data1), .rd_data_val_o(val1),
      .ram_rd_addr_o(ram_addr1), .ram_rd_en_o(en1), .ram_rd_data_i(ram_q1)
`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
      , .starve_o(starve1)
`endif
   );

   // Two-stage and one-stage RAM read models
   logic [63:0] r2_s1, r2_s2, r1_s1;
   always @(posedge clk) begin
      r2_s1 <= DBASE | 64'(ram_addr2);
      r2_s2 <= r2_s1;
      r1_s1 <= DBASE | 64'(ram_addr1);
   end
   assign ram_q2 = r2_s2;
   assign ram_q1 = r1_s1;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; outputs are then sampled 1 unit later
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic [39:0] a);
      @(negedge clk);
      req  = r;
      lock = l;
      addr = a;
      #1;
   endtask

   function automatic logic [9:0] eng_addr(input logic [3:0] oh, input logic [39:0] a);
      for (int k = 0; k < 4; k++) if (oh[k]) return a[k*10 +: 10];
      return 10'h0;
   endfunction

   // Watchdog so the run always terminates
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   logic [39:0] base_addr;
   logic [3:0]  s1_req  [7] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
   logic [3:0]  s1_gnt  [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
   logic [9:0]  s1_addr [7] = '{10'h10, 10'h20, 10'h30, 10'h40, 10'h40, 10'h40, 10'h40};
   logic [3:0]  s1_val2 [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
   logic [3:0]  s1_val1 [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
   logic [3:0]  s2_req  [7] = '{4'b0010, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0011, 4'b0011};
   logic [3:0]  s2_lock [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
   logic [3:0]  s2_gnt  [7] = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0010};

   initial begin
      int grants_seen;
      int starve_cyc, starve_cnt, gnt_cyc;
      logic [3:0] starve_val, gnt_val;
      logic [39:0] a3;

      base_addr = {10'h40, 10'h30, 10'h20, 10'h10};
      rst  = 1'b1;
      req  = '0;
      lock = '0;
      addr = base_addr;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset gnt", 64'(gnt2), 64'h0);
      checkOutput("reset val", 64'(val2), 64'h0);
      checkOutput("reset en", 64'(en2), 64'h0);
      checkOutput("reset addr", 64'(ram_addr2), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // All four engines request together, then drain
      for (int c = 0; c < 7; c++) begin
         applyStimulus(s1_req[c], 4'b0000, base_addr);
         checkOutput($sformatf("s1 gnt c%0d", c), 64'(gnt2), 64'(s1_gnt[c]));
         checkOutput($sformatf("s1 addr c%0d", c), 64'(ram_addr2), 64'(s1_addr[c]));
         checkOutput($sformatf("s1 en c%0d", c), 64'(en2), 64'(s1_gnt[c] != 0));
         checkOutput($sformatf("s1 val c%0d", c), 64'(val2), 64'(s1_val2[c]));
         if (s1_val2[c] != 0)
            checkOutput($sformatf("s1 data c%0d", c), data2, DBASE | 64'(eng_addr(s1_val2[c], base_addr)));
         checkOutput($sformatf("s1 lat1 val c%0d", c), 64'(val1), 64'(s1_val1[c]));
         if (s1_val1[c] != 0)
            checkOutput($sformatf("s1 lat1 data c%0d", c), data1, DBASE | 64'(eng_addr(s1_val1[c], base_addr)));
      end

      // Engine 2 locks for a 4-read burst while engines 0 and 1 keep requesting
      for (int c = 0; c < 7; c++) begin
         applyStimulus(s2_req[c], s2_lock[c], base_addr);
         checkOutput($sformatf("s2 gnt c%0d", c), 64'(gnt2), 64'(s2_gnt[c]));
         checkOutput($sformatf("s2 addr c%0d", c), 64'(ram_addr2), 64'(eng_addr(s2_gnt[c], base_addr)));
      end
      repeat (3) applyStimulus(4'b0000, 4'b0000, base_addr);

      // Engine 1 alone issues back-to-back reads with changing addresses
      for (int i = 0; i < 11; i++) begin
         a3 = base_addr;
         a3[19:10] = 10'h100 + 10'(i);
         applyStimulus((i < 8) ? 4'b0010 : 4'b0000, 4'b0000, a3);
         checkOutput($sformatf("s3 gnt i%0d", i), 64'(gnt2), (i < 8) ? 64'h2 : 64'h0);
         if (i < 8) checkOutput($sformatf("s3 addr i%0d", i), 64'(ram_addr2), 64'h100 + 64'(i));
         checkOutput($sformatf("s3 val i%0d", i), 64'(val2), (i >= 2 && i < 10) ? 64'h2 : 64'h0);
         if (i >= 2 && i < 10)
            checkOutput($sformatf("s3 data i%0d", i), data2, DBASE | (64'h100 + 64'(i - 2)));
      end

      // Engine 3 grant under lock, then reset one cycle later
      applyStimulus(4'b1000, 4'b1000, base_addr);
      checkOutput("s4 gnt3", 64'(gnt2), 64'h8);
      @(negedge clk);
      rst  = 1'b1;
      req  = '0;
      lock = '0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("s4 val in reset %0d", i), 64'(val2), 64'h0);
         @(negedge clk);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0000, 4'b0000, base_addr);
         checkOutput($sformatf("s4 val after reset %0d", i), 64'(val2), 64'h0);
      end
      applyStimulus(4'b1001, 4'b0000, base_addr);
      checkOutput("s4 ptr restart", 64'(gnt2), 64'h1);
      applyStimulus(4'b1000, 4'b0000, base_addr);
      checkOutput("s4 eng3 alone", 64'(gnt2), 64'h8);
      repeat (3) applyStimulus(4'b0000, 4'b0000, base_addr);

      // Engine 0 locks and goes quiet while engine 1 waits
      applyStimulus(4'b0011, 4'b0001, base_addr);
      checkOutput("s5 lock gnt0", 64'(gnt2), 64'h1);
`ifdef DATA_TABLE_RD_ARB_STARVE_GUARD_EN
      starve_cyc = -1; starve_cnt = 0; gnt_cyc = -1;
      starve_val = '0; gnt_val = '0;
      for (int i = 1; i <= 300 && gnt_cyc < 0; i++) begin
         applyStimulus(4'b0010, 4'b0001, base_addr);
         if (starve2 != 0) begin
            starve_cnt++;
            if (starve_cyc < 0) begin starve_cyc = i; starve_val = starve2; end
         end
         if (gnt2 != 0) begin gnt_cyc = i; gnt_val = gnt2; end
      end
      checkOutput("s5 starve cycle", 64'(starve_cyc), 64'd255);
      checkOutput("s5 starve vec", 64'(starve_val), 64'h2);
      checkOutput("s5 starve pulses", 64'(starve_cnt), 64'd1);
      checkOutput("s5 starved grant cycle", 64'(gnt_cyc), 64'd256);
      checkOutput("s5 starved grant", 64'(gnt_val), 64'h2);
      applyStimulus(4'b0000, 4'b0000, base_addr);
`else
      grants_seen = 0;
      for (int i = 1; i <= 300; i++) begin
         applyStimulus(4'b0010, 4'b0001, base_addr);
         if (gnt2 != 0) grants_seen++;
      end
      checkOutput("s5 no grant under lock", 64'(grants_seen), 64'd0);
      applyStimulus(4'b0010, 4'b0000, base_addr);
      checkOutput("s5 unlock cycle", 64'(gnt2), 64'h0);
      applyStimulus(4'b0010, 4'b0000, base_addr);
      checkOutput("s5 eng1 after unlock", 64'(gnt2), 64'h2);
      applyStimulus(4'b0000, 4'b0000, base_addr);
`endif

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
